sprite_fade_ctrl: RTL and testbench

Frame-synchronous fade controller for the 16-entry, 12-bit sprite palette path. It sequences a fade-in, hold, fade-out brightness envelope for an overlay screen, one step per N frames. It scales the palette's RGB output by the current level, flags transparent indices, and registers the result for the VGA color mux. It sits between the palette lookup and the color mapper.

---
 rtl/sprite_fade_ctrl.sv | 154 +++++++++++++++
 tb/tb_sprite_fade_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fade_ctrl.sv
// sprite_fade_ctrl: frame-synchronous fade-in / hold / fade-out envelope
// that scales the sprite palette colour and registers it for the VGA mux.
module sprite_fade_ctrl #(
    parameter int         FRAMES_PER_STEP = 4,
    parameter int         HOLD_FRAMES     = 120,
    parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       start,
    input  logic       abort,
    input  logic       pix_valid,
    input  logic [3:0] pix_index,
    input  logic [3:0] pal_red,
    input  logic [3:0] pal_green,
    input  logic [3:0] pal_blue,
    output logic [3:0] out_red,
    output logic [3:0] out_green,
    output logic [3:0] out_blue,
    output logic       out_valid,
    output logic       out_opaque,
    output logic [4:0] level,
    output logic       busy,
    output logic       done
);

    localparam int MAX_FRAMES =
        (FRAMES_PER_STEP > HOLD_FRAMES) ? FRAMES_PER_STEP : HOLD_FRAMES;
    localparam int CNT_W = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [4:0]       LEVEL_MAX = 5'd16;
    localparam logic [4:0]       LEVEL_TOP = 5'd15;
    localparam logic [4:0]       LEVEL_ONE = 5'd1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        HOLD     = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;

    // Channel scale: (pal * level) >> 4, exact pass-through at level 16.
    function automatic logic [3:0] scale(input logic [3:0] pal,
                                         input logic [4:0] lvl);
        logic [8:0] prod;
        prod = {5'd0, pal} * {4'd0, lvl};
        return 4'(prod >> 4);
    endfunction

    // Envelope sequencer: state, frame counter, level and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            frame_cnt <= '0;
            level     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                frame_cnt <= '0;
                level     <= '0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        level <= '0;
                        if (start) begin
                            state     <= FADE_IN;
                            frame_cnt <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    FADE_IN: begin
                        if (frame_start) begin
                            if (frame_cnt == STEP_LAST) begin
                                frame_cnt <= '0;
                                level     <= level + 5'd1;
                                if (level == LEVEL_TOP) begin
                                    state <= HOLD;
                                end
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        level <= LEVEL_MAX;
                        if (frame_start) begin
                            if (frame_cnt == HOLD_LAST) begin
                                state     <= FADE_OUT;
                                frame_cnt <= '0;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                    FADE_OUT: begin
                        if (frame_start) begin
                            if (frame_cnt == STEP_LAST) begin
                                frame_cnt <= '0;
                                level     <= level - 5'd1;
                                if (level == LEVEL_ONE) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        frame_cnt <= '0;
                        level     <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pixel path: one-cycle registered scale using the level held before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_red    <= '0;
            out_green  <= '0;
            out_blue   <= '0;
            out_valid  <= 1'b0;
            out_opaque <= 1'b0;
        end else begin
            out_valid  <= pix_valid;
            out_opaque <= pix_valid && (pix_index != TRANSPARENT_IDX);
            if (pix_valid) begin
                out_red   <= scale(pal_red, level);
                out_green <= scale(pal_green, level);
                out_blue  <= scale(pal_blue, level);
            end else begin
                out_red   <= '0;
                out_green <= '0;
                out_blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_fade_ctrl.sv
// tb_sprite_fade_ctrl: vector table plus envelope, abort, start-ignore
// and mid-sequence reset sequences for sprite_fade_ctrl.
module tb_sprite_fade_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       start;
    logic       abort;
    logic       pix_valid;
    logic [3:0] pix_index;
    logic [3:0] pal_red;
    logic [3:0] pal_green;
    logic [3:0] pal_blue;
    logic [3:0] out_red;
    logic [3:0] out_green;
    logic [3:0] out_blue;
    logic       out_valid;
    logic       out_opaque;
    logic [4:0] level;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       v;
        logic [3:0] idx;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pix_t;

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       v;
        logic       o;
    } exp_t;

    pix_t tbl[6];
    exp_t sb[$];

    sprite_fade_ctrl #(
        .FRAMES_PER_STEP(2),
        .HOLD_FRAMES(3),
        .TRANSPARENT_IDX(4'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .start(start),
        .abort(abort),
        .pix_valid(pix_valid),
        .pix_index(pix_index),
        .pal_red(pal_red),
        .pal_green(pal_green),
        .pal_blue(pal_blue),
        .out_red(out_red),
        .out_green(out_green),
        .out_blue(out_blue),
        .out_valid(out_valid),
        .out_opaque(out_opaque),
        .level(level),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    function automatic logic [3:0] model_scale(input logic [3:0] p, input int lvl);
        int x;
        x = (int'(p) * lvl) / 16;
        return x[3:0];
    endfunction

    function automatic int env_level(input int k);
        if (k <= 32) return k / 2;
        if (k <= 35) return 16;
        return 16 - (k - 35) / 2;
    endfunction

    task automatic run_table(input int lvl);
        exp_t e;
        exp_t got;
        chk("table_level", int'(level), lvl);
        for (int i = 0; i < 6; i++) begin
            pix_valid = tbl[i].v;
            pix_index = tbl[i].idx;
            pal_red   = tbl[i].r;
            pal_green = tbl[i].g;
            pal_blue  = tbl[i].b;
            e.v = tbl[i].v;
            e.o = tbl[i].v && (tbl[i].idx != 4'h0);
            e.r = tbl[i].v ? model_scale(tbl[i].r, lvl) : 4'h0;
            e.g = tbl[i].v ? model_scale(tbl[i].g, lvl) : 4'h0;
            e.b = tbl[i].v ? model_scale(tbl[i].b, lvl) : 4'h0;
            sb.push_back(e);
            step();
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                got = sb.pop_front();
                chk("out_red", int'(out_red), int'(got.r));
                chk("out_green", int'(out_green), int'(got.g));
                chk("out_blue", int'(out_blue), int'(got.b));
                chk("out_valid", int'(out_valid), int'(got.v));
                chk("out_opaque", int'(out_opaque), int'(got.o));
            end
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        int dones;
        tbl[0] = '{1'b1, 4'h8, 4'hF, 4'hF, 4'hF};
        tbl[1] = '{1'b1, 4'h8, 4'hA, 4'hE, 4'hA};
        tbl[2] = '{1'b1, 4'h0, 4'hF, 4'hF, 4'hF};
        tbl[3] = '{1'b0, 4'h8, 4'hF, 4'hF, 4'hF};
        tbl[4] = '{1'b1, 4'h3, 4'h1, 4'h7, 4'hC};
        tbl[5] = '{1'b1, 4'hF, 4'h8, 4'h0, 4'h3};

        reset = 1'b1;
        frame_start = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pix_valid = 1'b0;
        pix_index = 4'h0;
        pal_red = 4'h0;
        pal_green = 4'h0;
        pal_blue = 4'h0;
        step();
        step();
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_opaque", int'(out_opaque), 0);
        chk("rst_rgb", int'({out_red, out_green, out_blue}), 0);
        reset = 1'b0;
        step();

        run_table(0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_level", int'(level), 0);
        dones = 0;
        for (int k = 1; k <= 67; k++) begin
            frame();
            chk("env_level", int'(level), env_level(k));
            chk("env_done", int'(done), (k == 67) ? 1 : 0);
            chk("env_busy", int'(busy), (k == 67) ? 0 : 1);
            if (done) dones++;
            if (k == 16) run_table(8);
            if (k == 32) run_table(16);
            if (k == 33) begin
                start = 1'b1;
                step();
                start = 1'b0;
                chk("hold_start_level", int'(level), 16);
                chk("hold_start_busy", int'(busy), 1);
            end
        end
        step();
        chk("done_once", dones, 1);
        chk("done_drop", int'(done), 0);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 18; k++) frame();
        chk("pre_abort_level", int'(level), 9);
        abort = 1'b1;
        frame_start = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        frame_start = 1'b0;
        start = 1'b0;
        chk("abort_level", int'(level), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        for (int k = 0; k < 4; k++) begin
            frame();
            chk("idle_level", int'(level), 0);
            chk("idle_done", int'(done), 0);
        end

        start = 1'b1;
        frame_start = 1'b1;
        step();
        start = 1'b0;
        frame_start = 1'b0;
        chk("sf_busy", int'(busy), 1);
        chk("sf_level", int'(level), 0);
        frame();
        chk("sf_level_1st", int'(level), 0);
        frame();
        chk("sf_level_2nd", int'(level), 1);
        for (int k = 3; k <= 40; k++) frame();
        chk("fo_level", int'(level), 14);
        pix_valid = 1'b1;
        pix_index = 4'h8;
        pal_red = 4'hF;
        pal_green = 4'hF;
        pal_blue = 4'hF;
        step();
        chk("pre_rst_valid", int'(out_valid), 1);
        chk("pre_rst_red", int'(out_red), 13);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_opaque", int'(out_opaque), 0);
        chk("arst_rgb", int'({out_red, out_green, out_blue}), 0);
        pix_valid = 1'b0;
        frame();
        frame();
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            frame();
            if (done) dones++;
        end
        chk("post_rst_level", int'(level), 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_done", dones, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
